// File: rtl/altusoc_gpio_pkg.sv
// altusoc_gpio_pkg: register word addresses and interrupt type/polarity encodings
package altusoc_gpio_pkg;
    localparam logic [4:0] REG_DATA_IN  = 5'd0;
    localparam logic [4:0] REG_DATA_OUT = 5'd1;
    localparam logic [4:0] REG_DIR      = 5'd2;
    localparam logic [4:0] REG_IRQ_EN   = 5'd3;
    localparam logic [4:0] REG_IRQ_TYPE = 5'd4;
    localparam logic [4:0] REG_IRQ_POL  = 5'd5;
    localparam logic [4:0] REG_IRQ_PEND = 5'd6;
    localparam logic [4:0] REG_IRQ_SET  = 5'd7;
    localparam logic TYPE_LEVEL = 1'b0;
    localparam logic TYPE_EDGE  = 1'b1;
    localparam logic POL_LOW    = 1'b0;
    localparam logic POL_HIGH   = 1'b1;
endpackage

// File: rtl/altusoc_sync_chain.sv
// altusoc_sync_chain: reset-to-zero multi-flop input synchroniser
module altusoc_sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
    always_comb stage_d = {stage_q[STAGES-2:0], d};
    always_ff @(posedge clk) stage_q <= rst ? '0 : stage_d;
    assign q = stage_q[STAGES-1];
endmodule

// File: rtl/altusoc_gpio_irq.sv
// altusoc_gpio_irq: Wishbone GPIO with synchronised inputs and level/edge interrupts
module altusoc_gpio_irq
    import altusoc_gpio_pkg::*;
#(
    parameter int N_GPIO      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [4:0]        i_wb_adr,
    input  logic [31:0]       i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    output logic [31:0]       o_wb_rdt,
    output logic              o_wb_ack,
    input  logic [N_GPIO-1:0] i_gpio,
    output logic [N_GPIO-1:0] o_gpio,
    output logic [N_GPIO-1:0] o_gpio_oe,
    output logic              o_irq
);
    localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);
    logic [N_GPIO-1:0] sin, prev_q, prev_d, out_q, out_d, dir_q, dir_d, en_q, en_d;
    logic [N_GPIO-1:0] type_q, type_d, pol_q, pol_d, pend_q, pend_d;
    logic [N_GPIO-1:0] wmask, wbits, rise, fall, evt;
    logic [31:0]       lane, rd, rdt_q, rdt_d;
    logic [2:0]        prime_q, prime_d;
    logic              ack_q, ack_d, irq_q, irq_d, acc, wr, primed;

    altusoc_sync_chain #(.WIDTH(N_GPIO), .STAGES(SYNC_STAGES)) u_sync (
        .clk(i_clk), .rst(i_rst), .d(i_gpio), .q(sin)
    );

    always_comb begin
        acc     = i_wb_cyc & i_wb_stb & ~ack_q;
        wr      = acc & i_wb_we;
        lane    = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
        wmask   = lane[N_GPIO-1:0];
        wbits   = i_wb_dat[N_GPIO-1:0] & wmask;
        primed  = prime_q == PRIME_DONE;
        rise    = sin & ~prev_q;
        fall    = ~sin & prev_q;
        // edge events stay masked until the zero-reset chain has flushed real pin values through prev
        evt     = (type_q & ((pol_q & rise) | (~pol_q & fall)) & {N_GPIO{primed}})
                | (~type_q & ((pol_q & sin) | (~pol_q & ~sin)));
        out_d   = wr && i_wb_adr == REG_DATA_OUT ? (out_q & ~wmask) | wbits : out_q;
        dir_d   = wr && i_wb_adr == REG_DIR ? (dir_q & ~wmask) | wbits : dir_q;
        en_d    = wr && i_wb_adr == REG_IRQ_EN ? (en_q & ~wmask) | wbits : en_q;
        type_d  = wr && i_wb_adr == REG_IRQ_TYPE ? (type_q & ~wmask) | wbits : type_q;
        pol_d   = wr && i_wb_adr == REG_IRQ_POL ? (pol_q & ~wmask) | wbits : pol_q;
        pend_d  = (pend_q & ~(wr && i_wb_adr == REG_IRQ_PEND ? wbits : '0)) | evt
                | (wr && i_wb_adr == REG_IRQ_SET ? wbits : '0);
        prime_d = primed ? prime_q : prime_q + 3'd1;
        prev_d  = sin;
        ack_d   = acc;
        irq_d   = |(pend_q & en_q);
        rd      = '0;
        case (i_wb_adr)
            REG_DATA_IN:  rd = 32'(sin);
            REG_DATA_OUT: rd = 32'(out_q);
            REG_DIR:      rd = 32'(dir_q);
            REG_IRQ_EN:   rd = 32'(en_q);
            REG_IRQ_TYPE: rd = 32'(type_q);
            REG_IRQ_POL:  rd = 32'(pol_q);
            REG_IRQ_PEND: rd = 32'(pend_q);
            default:      rd = '0;
        endcase
        rdt_d   = acc ? rd : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_q  <= '0;
            out_q   <= '0;
            dir_q   <= '0;
            en_q    <= '0;
            type_q  <= '0;
            pol_q   <= '0;
            pend_q  <= '0;
            prime_q <= '0;
            rdt_q   <= '0;
            ack_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            out_q   <= out_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            type_q  <= type_d;
            pol_q   <= pol_d;
            pend_q  <= pend_d;
            prime_q <= prime_d;
            rdt_q   <= rdt_d;
            ack_q   <= ack_d;
            irq_q   <= irq_d;
        end
    end

    assign o_wb_rdt  = rdt_q;
    assign o_wb_ack  = ack_q;
    assign o_gpio    = out_q;
    assign o_gpio_oe = dir_q;
    assign o_irq     = irq_q;
endmodule

// File: tb/tb_altusoc_gpio_irq.sv
// tb_altusoc_gpio_irq: directed bench with a cycle-level reference model and literal checks
module tb_altusoc_gpio_irq;
    localparam int S = 2;
    logic        clk = 1'b0, rst = 1'b1;
    logic [4:0]  adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic [31:0] gpio = '0;
    logic [31:0] rdt, gout, goe, rdt8;
    logic [7:0]  gout8, goe8;
    logic        ack, irq, ack8, irq8;
    logic [31:0] last_rd, last_rd8;
    int          checks = 0, failures = 0;
    bit          live = 1'b0;

    always #5 clk = ~clk;

    altusoc_gpio_irq #(.N_GPIO(32), .SYNC_STAGES(S)) dut (
        .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_rdt(rdt), .o_wb_ack(ack),
        .i_gpio(gpio), .o_gpio(gout), .o_gpio_oe(goe), .o_irq(irq)
    );

    altusoc_gpio_irq #(.N_GPIO(8), .SYNC_STAGES(4)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_rdt(rdt8), .o_wb_ack(ack8),
        .i_gpio(gpio[7:0]), .o_gpio(gout8), .o_gpio_oe(goe8), .o_irq(irq8)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // reference model: pin history queue-like array, edges-since-reset count, register image
    logic [31:0] m_out, m_dir, m_en, m_type, m_pol, m_pend, m_rdt;
    logic        m_ack, m_irq;
    logic [31:0] hist [0:7];
    int          nsmp;

    function automatic logic [31:0] m_sin();
        return nsmp >= S ? hist[S-1] : 32'h0;
    endfunction

    function automatic logic [31:0] m_prev();
        return nsmp >= S + 1 ? hist[S] : 32'h0;
    endfunction

    function automatic logic [31:0] m_mask();
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic m_acc();
        return cyc && stb && !m_ack;
    endfunction

    function automatic logic m_wr(input int a);
        return m_acc() && we && adr == 5'(a);
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] r);
        return (r & ~m_mask()) | (dat & m_mask());
    endfunction

    function automatic logic [31:0] m_evt();
        logic [31:0] s = m_sin(), p = m_prev(), e;
        for (int i = 0; i < 32; i++)
            e[i] = m_type[i] ? (nsmp > S && (m_pol[i] ? (s[i] && !p[i]) : (!s[i] && p[i])))
                             : (m_pol[i] ? s[i] : !s[i]);
        return e;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd0: return m_sin();
            5'd1: return m_out;
            5'd2: return m_dir;
            5'd3: return m_en;
            5'd4: return m_type;
            5'd5: return m_pol;
            5'd6: return m_pend;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            {m_out, m_dir, m_en, m_type, m_pol, m_pend, m_rdt} <= '0;
            m_ack <= 1'b0;
            m_irq <= 1'b0;
            nsmp  <= 0;
        end else begin
            m_ack  <= m_acc();
            m_rdt  <= m_acc() ? m_read(adr) : 32'h0;
            m_irq  <= |(m_pend & m_en);
            m_pend <= (m_pend & ~(m_wr(6) ? dat & m_mask() : 32'h0)) | m_evt()
                    | (m_wr(7) ? dat & m_mask() : 32'h0);
            if (m_wr(1)) m_out <= m_merge(m_out);
            if (m_wr(2)) m_dir <= m_merge(m_dir);
            if (m_wr(3)) m_en <= m_merge(m_en);
            if (m_wr(4)) m_type <= m_merge(m_type);
            if (m_wr(5)) m_pol <= m_merge(m_pol);
            for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= gpio;
            nsmp    <= nsmp < 16 ? nsmp + 1 : nsmp;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("ack", 32'(ack), 32'(m_ack));
            chk("rdt", rdt, m_rdt);
            chk("irq", 32'(irq), 32'(m_irq));
            chk("gpio", gout, m_out);
            chk("oe", goe, m_dir);
        end
    end

    task automatic wb(input int a, input logic w, input logic [31:0] d, input logic [3:0] s);
        bit got = 1'b0;
        adr = 5'(a); we = w; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk);
            #1;
            got = ack;
        end
        if (!got) chk("ack_timeout", 32'(got), 32'h1);
        last_rd  = rdt;
        last_rd8 = rdt8;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        int offs[8] = '{0, 1, 2, 3, 4, 5, 7, 8};
        repeat (3) @(posedge clk);
        @(negedge clk);
        live = 1'b1;
        rst  = 1'b0;
        wb(6, 0, 0, 0);
        chk("rd_pend_rst", last_rd, 32'h0);
        foreach (offs[i]) begin
            wb(offs[i], 0, 0, 0);
            chk($sformatf("rd_rst_%0d", offs[i]), last_rd, 32'h0);
        end
        chk("irq_rst", 32'(irq), 32'h0);
        wb(4, 1, 32'hFFFF_FFFF, 4'hF);
        wb(6, 1, 32'hFFFF_FFFF, 4'hF);
        wb(6, 0, 0, 0);
        chk("pend_cleared", last_rd, 32'h0);
        wb(1, 1, 32'hA5A5_A5A5, 4'b0011);
        wb(2, 1, 32'hFFFF_FFFF, 4'hF);
        chk("gpio_lanes", gout, 32'h0000_A5A5);
        chk("oe_all", goe, 32'hFFFF_FFFF);
        chk("gpio8_lanes", 32'(gout8), 32'h0000_00A5);
        wb(3, 1, 32'h8, 4'hF);
        wb(5, 1, 32'h8, 4'hF);
        gpio = 32'h8;
        repeat (3) @(posedge clk);
        #1 chk("irq_before_s2", 32'(irq), 32'h0);
        @(posedge clk);
        #1 chk("irq_at_s2", 32'(irq), 32'h1);
        wb(6, 0, 0, 0);
        chk("pend_edge", last_rd, 32'h8);
        wb(6, 1, 32'h8, 4'hF);
        @(posedge clk);
        #1 chk("irq_w1c", 32'(irq), 32'h0);
        wb(5, 1, 32'h28, 4'hF);
        wb(3, 1, 32'h28, 4'hF);
        wb(4, 1, 32'hFFFF_FFDF, 4'hF);
        gpio = 32'h28;
        repeat (4) @(posedge clk);
        #1 chk("irq_level", 32'(irq), 32'h1);
        wb(6, 0, 0, 0);
        chk("pend_level", last_rd, 32'h20);
        wb(6, 1, 32'h20, 4'hF);
        chk("irq_level_hold", 32'(irq), 32'h1);
        wb(6, 0, 0, 0);
        chk("pend_level_reset", last_rd, 32'h20);
        gpio = 32'h8;
        repeat (3) @(posedge clk);
        #1 wb(6, 1, 32'h20, 4'hF);
        wb(6, 0, 0, 0);
        chk("pend_level_gone", last_rd, 32'h0);
        chk("irq_level_gone", 32'(irq), 32'h0);
        wb(4, 1, 32'hFFFF_FFFF, 4'hF);
        wb(6, 1, 32'hFFFF_FFFF, 4'hF);
        gpio = 32'hA;
        repeat (4) @(posedge clk);
        #1 wb(7, 1, 32'h1, 4'hF);
        gpio = 32'h8;
        repeat (2) @(posedge clk);
        #1 wb(6, 1, 32'h2, 4'hF);
        wb(6, 0, 0, 0);
        chk("pend_set_fall", last_rd, 32'h3);
        wb(7, 0, 0, 0);
        chk("set_reads0", last_rd, 32'h0);
        wb(1, 1, 32'hFFFF_FFFF, 4'hF);
        wb(1, 0, 0, 0);
        chk("out_rd32", last_rd, 32'hFFFF_FFFF);
        chk("out_rd8", last_rd8, 32'h0000_00FF);
        wb(2, 0, 0, 0);
        chk("dir_rd8", last_rd8, 32'h0000_00FF);
        wb(0, 0, 0, 0);
        chk("din_rd8", last_rd8, 32'h0000_0008);
        gpio = 32'hFFFF_FFFF;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wb(4, 1, 32'hFFFF_FFFF, 4'hF);
        wb(5, 1, 32'hFFFF_FFFF, 4'hF);
        wb(6, 1, 32'hFFFF_FFFF, 4'hF);
        wb(6, 0, 0, 0);
        chk("prime_pend32", last_rd, 32'h0);
        chk("prime_pend8", last_rd8, 32'h0);
        wb(0, 0, 0, 0);
        chk("prime_din32", last_rd, 32'hFFFF_FFFF);
        chk("prime_din8", last_rd8, 32'h0000_00FF);
        chk("prime_irq", 32'(irq), 32'h0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
